rpn_alu_datapath: RTL

//  Datapath partner of the reverse-polish calculator control FSM. Consumes its

---
 rtl/rpn_alu_datapath.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rpn_alu_datapath.sv
// rpn_alu_datapath: operand/opcode latches, single-cycle ALU and iterative shift-add multiply for the RPN calculator
module rpn_alu_datapath #(
    parameter int WIDTH = 16,
    parameter int OPC_W = 3
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             LoadOpA,
    input  logic             LoadOpB,
    input  logic             LoadOpCode,
    input  logic             updateRes,
    input  logic             ToDisplaySel,
    output logic [WIDTH-1:0] ToDisplay,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags,
    output logic             Busy,
    output logic             ResValid,
    output logic             OpErr
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    state_t state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, a_now, b_now, alu_r, mplier;
    logic [OPC_W-1:0] op_code, op_now;
    logic [2*WIDTH-1:0] mcand, acc, acc_nx;
    logic [WIDTH:0] sum, diff;
    logic [CW-1:0] cnt;
    logic upd_q, start, is_mul, last, alu_c, alu_v, alu_err;

    function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r, input logic c, input logic v);
        return {r[WIDTH-1], ~|r, c, v};
    endfunction

    // a load in the same cycle as start must reach the snapshot
    assign a_now  = LoadOpA ? DataIn : op_a;
    assign b_now  = LoadOpB ? DataIn : op_b;
    assign op_now = LoadOpCode ? DataIn[OPC_W-1:0] : op_code;
    assign start  = updateRes & ~upd_q;
    assign is_mul = op_now == OPC_W'(2);
    assign last   = cnt == CW'(1);
    assign acc_nx = acc + (mplier[0] ? mcand : '0);
    assign ToDisplay = ToDisplaySel ? Result : DataIn;

    always_comb begin
        sum     = {1'b0, a_now} + {1'b0, b_now};
        diff    = {1'b0, a_now} + {1'b0, ~b_now} + (WIDTH + 1)'(1);
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_now)
            OPC_W'(0): begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a_now[WIDTH-1] == b_now[WIDTH-1]) && (sum[WIDTH-1] != a_now[WIDTH-1]);
            end
            OPC_W'(1): begin
                alu_r = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (a_now[WIDTH-1] != b_now[WIDTH-1]) && (diff[WIDTH-1] != a_now[WIDTH-1]);
            end
            OPC_W'(2): alu_r = '0;
            OPC_W'(3): alu_r = a_now & b_now;
            OPC_W'(4): alu_r = a_now | b_now;
            OPC_W'(5): alu_r = a_now ^ b_now;
            default:   alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge Reset)
        if (Reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (start ? (is_mul ? CALC : DONE) : IDLE)
                 : state == CALC ? (!updateRes ? IDLE : last ? DONE : CALC)
                 : state == DONE ? (updateRes ? DONE : IDLE)
                 : IDLE;
    end

    always_comb begin
        Busy     = state == CALC;
        ResValid = state == DONE;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            upd_q   <= 1'b0;
            Result  <= '0;
            Flags   <= '0;
            OpErr   <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            upd_q <= updateRes;
            if (LoadOpA) op_a <= DataIn;
            if (LoadOpB) op_b <= DataIn;
            if (LoadOpCode) op_code <= DataIn[OPC_W-1:0];
            if (state == IDLE && start) begin
                mcand  <= {{WIDTH{1'b0}}, a_now};
                mplier <= b_now;
                acc    <= '0;
                cnt    <= CW'(WIDTH);
                OpErr  <= alu_err;
                Result <= alu_r;
                Flags  <= is_mul ? 4'b0000 : nzcv(alu_r, alu_c, alu_v);
            end else if (state == CALC) begin
                if (!updateRes) begin
                    Result <= '0;
                    Flags  <= '0;
                end else begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (last) begin
                        Result <= acc_nx[WIDTH-1:0];
                        Flags  <= nzcv(acc_nx[WIDTH-1:0], |acc_nx[2*WIDTH-1:WIDTH], |acc_nx[2*WIDTH-1:WIDTH]);
                    end
                end
            end
        end
    end
endmodule
